// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : cond_logic
// Purpose  : Conditional-execution unit for the single-cycle ARM datapath.
//            Holds the N,Z,C,V flag register, evaluates the instruction
//            condition field against the stored flags, and gates the
//            PC-select, register-write and memory-write enables.
// Revision : 1.0 - initial release
// ============================================================================
module cond_logic (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       NoWrite,
    input  logic       MemW,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Carry,
    output logic [3:0] Flags
);

    // Condition-field encodings
    localparam logic [3:0] c_EQ = 4'b0000;
    localparam logic [3:0] c_NE = 4'b0001;
    localparam logic [3:0] c_CS = 4'b0010;
    localparam logic [3:0] c_CC = 4'b0011;
    localparam logic [3:0] c_MI = 4'b0100;
    localparam logic [3:0] c_PL = 4'b0101;
    localparam logic [3:0] c_VS = 4'b0110;
    localparam logic [3:0] c_VC = 4'b0111;
    localparam logic [3:0] c_HI = 4'b1000;
    localparam logic [3:0] c_LS = 4'b1001;
    localparam logic [3:0] c_GE = 4'b1010;
    localparam logic [3:0] c_LT = 4'b1011;
    localparam logic [3:0] c_GT = 4'b1100;
    localparam logic [3:0] c_LE = 4'b1101;
    localparam logic [3:0] c_AL = 4'b1110;

    logic [1:0] r_nz;          // {N,Z}
    logic [1:0] r_cv;          // {C,V}
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_cond_ex;
    logic [1:0] w_flag_write;

    assign w_n = r_nz[1];
    assign w_z = r_nz[0];
    assign w_c = r_cv[1];
    assign w_v = r_cv[0];

    // Evaluate the condition field on the stored flags only (never ALUFlags),
    // so a flag-setting instruction is conditioned on the previous flags.
    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            c_EQ:    w_cond_ex = w_z;
            c_NE:    w_cond_ex = ~w_z;
            c_CS:    w_cond_ex = w_c;
            c_CC:    w_cond_ex = ~w_c;
            c_MI:    w_cond_ex = w_n;
            c_PL:    w_cond_ex = ~w_n;
            c_VS:    w_cond_ex = w_v;
            c_VC:    w_cond_ex = ~w_v;
            c_HI:    w_cond_ex = w_c & ~w_z;
            c_LS:    w_cond_ex = ~w_c | w_z;
            c_GE:    w_cond_ex = (w_n == w_v);
            c_LT:    w_cond_ex = (w_n != w_v);
            c_GT:    w_cond_ex = ~w_z & (w_n == w_v);
            c_LE:    w_cond_ex = w_z | (w_n != w_v);
            c_AL:    w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;   // 1111 is treated as a NOP
        endcase
    end

    // Flag halves update independently; a busy multi-cycle unit freezes them.
    assign w_flag_write = FlagW & {2{w_cond_ex & ~Stall}};

    // Flag register: async clear, per-half load from the ALU.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_nz <= 2'b00;
            r_cv <= 2'b00;
        end else begin
            if (w_flag_write[1]) r_nz <= ALUFlags[3:2];
            if (w_flag_write[0]) r_cv <= ALUFlags[1:0];
        end
    end

    // Stall is intentionally not applied here; the top level holds the PC.
    assign PCSrc    = PCS & w_cond_ex;
    assign RegWrite = RegW & w_cond_ex & ~NoWrite;
    assign MemWrite = MemW & w_cond_ex;

    // Carry comes from the stored C, which breaks any loop through the ALU.
    assign Carry = w_c;
    assign Flags = {r_nz, r_cv};

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_logic
// Purpose  : Scoreboard testbench for cond_logic. Stimulus pushes expected
//            {PCSrc,RegWrite,MemWrite,Carry,Flags} vectors; a monitor pops
//            and compares them on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_logic;

    logic       CLK;
    logic       RESET;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       NoWrite;
    logic       MemW;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       Carry;
    logic [3:0] Flags;

    cond_logic dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .NoWrite  (NoWrite),
        .MemW     (MemW),
        .Stall    (Stall),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Carry    (Carry),
        .Flags    (Flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Hand-computed CondEx per code, bit index = Cond.
    // Flags 0110 (N0 Z1 C1 V0): EQ1 NE0 CS1 CC0 MI0 PL1 VS0 VC1 HI0 LS1 GE1 LT0 GT0 LE1 AL1 NV0
    logic [15:0] tbl_0110 = 16'b0110_0110_1010_0101;
    // Flags 1001 (N1 Z0 C0 V1): EQ0 NE1 CS0 CC1 MI1 PL0 VS1 VC0 HI0 LS1 GE1 LT0 GT1 LE0 AL1 NV0
    logic [15:0] tbl_1001 = 16'b0101_0110_0101_1010;

    // Monitor: compare every pending expectation against the settled outputs.
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            n_checks++;
            if ({PCSrc, RegWrite, MemWrite, Carry, Flags} === m_e.exp)
                n_pass++;
            else
                $display("FAIL %s: got %b expected %b", m_e.name,
                         {PCSrc, RegWrite, MemWrite, Carry, Flags}, m_e.exp);
        end
    end

    task automatic push(input string name, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                         input logic pcs, input logic rw, input logic nw, input logic mw,
                         input logic st);
        Cond = c; ALUFlags = af; FlagW = fw; PCS = pcs;
        RegW = rw; NoWrite = nw; MemW = mw; Stall = st;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        // During reset outputs evaluate with flags = 0
        push("in_reset_al", 8'b0100_0000);
        step();
        RESET = 1'b0;
        drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push("rst_eq_regwrite", 8'b0000_0000);
        step();
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push("rst_al_regwrite", 8'b0100_0000);
        step();

        // Full load then partial writes
        drive(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("load_pre", 8'b0000_0000);
        step();
        drive(4'b1110, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("load_all", 8'b0001_1111);
        step();
        drive(4'b1110, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("partial_nz", 8'b0001_0011);
        step();
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("partial_cv", 8'b0000_0000);

        // Condition sweep, flags 0110
        drive(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            push($sformatf("sweep0110_c%0d", i),
                 {{3{tbl_0110[i]}}, 1'b1, 4'b0110});
            step();
        end

        // Condition sweep, flags 1001
        drive(4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            push($sformatf("sweep1001_c%0d", i),
                 {{3{tbl_1001[i]}}, 1'b0, 4'b1001});
            step();
        end

        // Failed condition with FlagW=11
        drive(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        push("fail_cond_en", 8'b0000_0000);
        step();
        drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("fail_cond_hold", 8'b0000_0000);
        step();

        // CMP: flags written, register write suppressed
        drive(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push("cmp_regwrite", 8'b0000_0000);
        step();
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("cmp_flags", 8'b0000_0100);
        step();

        // Stall holds flags for 3 edges, write lands on the release edge
        drive(4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push($sformatf("stall_hold%0d", i), 8'b0000_0100);
            step();
        end
        drive(4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("stall_release_pre", 8'b0000_0100);
        step();
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("stall_release_write", 8'b0001_1010);
        step();

        // Async reset between edges with a held flag write
        drive(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        push("async_pre", 8'b0001_1111);
        step();
        #1;
        RESET = 1'b1;
        push("async_clear", 8'b0000_0000);
        step();
        push("reset_blocks_write", 8'b0000_0000);
        step();
        RESET = 1'b0;
        push("reset_release", 8'b0000_0000);
        step();
        push("post_reset_write", 8'b0001_1111);
        step();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
